// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: synchronises the PIC INT line, runs the two-pulse INTA handshake,
// captures the vector on the second pulse and hands it to the CPU over valid/ready.
module pic_inta_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       int_in,
  input  logic       if_enable,
  input  logic [7:0] data_in,
  output logic       inta_n,
  output logic [7:0] vector_out,
  output logic       vector_valid,
  input  logic       vector_ready,
  output logic       busy,
  output logic [7:0] irq_count
);
  localparam int MAXC = PULSE_CYCLES > GAP_CYCLES ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] PLOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GLOAD = CW'(GAP_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, ACK1, GAP, ACK2, HOLD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic inta_n_q, busy_q, valid_q;
  logic [7:0] vec_q, irq_q;
  logic int_sync, done;
  assign int_sync = sync_q[SYNC_STAGES-1];
  assign done = cnt_q == '0;
  always_comb begin
    state_d = state_q;
    cnt_d = done ? cnt_q : cnt_q - 1'b1;
    case (state_q)
      IDLE: if (int_sync && if_enable && !valid_q) begin state_d = ACK1; cnt_d = PLOAD; end
      ACK1: if (done) begin state_d = GAP; cnt_d = GLOAD; end
      GAP:  if (done) begin state_d = ACK2; cnt_d = PLOAD; end
      ACK2: if (done) state_d = HOLD;
      HOLD: if (vector_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs are decoded from the next state so they move on the same edge as the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      state_q <= IDLE;
      cnt_q <= '0;
      inta_n_q <= 1'b1;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
      vec_q <= '0;
      irq_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], int_in};
      state_q <= state_d;
      cnt_q <= cnt_d;
      inta_n_q <= !(state_d == ACK1 || state_d == ACK2);
      busy_q <= state_d != IDLE;
      valid_q <= state_d == HOLD;
      if (state_q == ACK2 && state_d == HOLD) vec_q <= data_in;
      if (state_q == HOLD && state_d == IDLE) irq_q <= irq_q + 1'b1;
    end
  end
  assign inta_n = inta_n_q;
  assign busy = busy_q;
  assign vector_valid = valid_q;
  assign vector_out = vec_q;
  assign irq_count = irq_q;
endmodule

// File: tb/tb_pic_inta_sequencer.sv
// tb_pic_inta_sequencer: drives a default instance and a PULSE=3/GAP=2 instance in lockstep
// and checks both against a timeline model of the INTA sequence.
module tb_pic_inta_sequencer;
  logic clk = 0, rst_n = 0, int_in = 0, if_enable = 0, vector_ready = 0;
  logic [7:0] data_in = 0;
  logic inta_n_w [2], valid_w [2], busy_w [2];
  logic [7:0] vec_w [2], cnt_w [2];
  int n_chk = 0, n_fail = 0;
  int pc [2] = '{2, 3};
  int gc [2] = '{1, 2};
  logic m_act [2], m_val [2];
  int m_e [2], m_acc [2];
  logic [7:0] m_vec [2], m_cnt [2];
  logic d1 = 0, d2 = 0, chk_on = 0;
  logic [7:0] pat [2];
  bit seen [2];

  always #5 clk = ~clk;

  pic_inta_sequencer dut_a (.clk(clk), .rst_n(rst_n), .int_in(int_in), .if_enable(if_enable),
    .data_in(data_in), .inta_n(inta_n_w[0]), .vector_out(vec_w[0]), .vector_valid(valid_w[0]),
    .vector_ready(vector_ready), .busy(busy_w[0]), .irq_count(cnt_w[0]));
  pic_inta_sequencer #(.PULSE_CYCLES(3), .GAP_CYCLES(2)) dut_b (.clk(clk), .rst_n(rst_n),
    .int_in(int_in), .if_enable(if_enable), .data_in(data_in), .inta_n(inta_n_w[1]),
    .vector_out(vec_w[1]), .vector_valid(valid_w[1]), .vector_ready(vector_ready),
    .busy(busy_w[1]), .irq_count(cnt_w[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a sequence is a timeline of elapsed edges e since the start edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 = 0; d2 = 0;
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 0; m_val[k] = 0; m_e[k] = 0; m_acc[k] = 0; m_vec[k] = 0; m_cnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_act[k]) begin
          m_e[k]++;
          if (m_e[k] == 2 * pc[k] + gc[k]) begin m_act[k] = 0; m_val[k] = 1; m_vec[k] = data_in; end
        end else if (m_val[k]) begin
          if (vector_ready) begin m_val[k] = 0; m_cnt[k]++; m_acc[k]++; end
        end else if (d2 && if_enable) begin
          m_act[k] = 1; m_e[k] = 0;
        end
      end
      d2 = d1; d1 = int_in;
    end
  end

  function automatic logic exp_inta(input int k);
    return !(m_act[k] && (m_e[k] < pc[k] || m_e[k] >= pc[k] + gc[k]));
  endfunction

  always @(negedge clk) begin
    if (rst_n && chk_on)
      for (int k = 0; k < 2; k++) begin
        chk(k ? "b.inta_n" : "a.inta_n", 32'(inta_n_w[k]), 32'(exp_inta(k)));
        chk(k ? "b.busy" : "a.busy", 32'(busy_w[k]), 32'(m_act[k] || m_val[k]));
        chk(k ? "b.valid" : "a.valid", 32'(valid_w[k]), 32'(m_val[k]));
        chk(k ? "b.vector" : "a.vector", 32'(vec_w[k]), 32'(m_vec[k]));
        chk(k ? "b.irq_count" : "a.irq_count", 32'(cnt_w[k]), 32'(m_cnt[k]));
      end
  end

  task automatic drain();
    @(negedge clk); int_in = 0; vector_ready = 1;
    repeat (30) @(negedge clk);
    vector_ready = 0;
  endtask

  task automatic wait_valid(input string nm);
    int t = 0;
    while (!(m_val[0] && m_val[1]) && t < 60) begin @(negedge clk); t++; end
    chk({nm, ".timeout"}, 32'(t < 60), 32'd1);
  endtask

  initial begin
    pat[0] = 8'b1001_0011;
    pat[1] = 8'b0110_0011;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst.inta_n", 32'(inta_n_w[k]), 32'd1);
      chk("rst.valid", 32'(valid_w[k]), 32'd0);
      chk("rst.busy", 32'(busy_w[k]), 32'd0);
      chk("rst.count", 32'(cnt_w[k]), 32'd0);
    end
    rst_n = 1; chk_on = 1;
    repeat (2) @(negedge clk);
    // basic sequence with literal edge-by-edge expectations
    int_in = 1; if_enable = 1; data_in = 8'h48;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("basic.a.inta_n", 32'(inta_n_w[0]), 32'(pat[0][i]));
      chk("basic.b.inta_n", 32'(inta_n_w[1]), 32'(pat[1][i]));
    end
    chk("basic.valid", 32'(valid_w[0]), 32'd1);
    chk("basic.vector", 32'(vec_w[0]), 32'h48);
    vector_ready = 1;
    @(negedge clk);
    vector_ready = 0; int_in = 0;
    chk("basic.ack.valid", 32'(valid_w[0]), 32'd0);
    chk("basic.ack.count", 32'(cnt_w[0]), 32'd1);
    chk("basic.ack.busy", 32'(busy_w[0]), 32'd0);
    drain();
    // if_enable gating
    if_enable = 0; int_in = 1;
    repeat (20) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("gate.inta_n", 32'(inta_n_w[k]), 32'd1);
        chk("gate.busy", 32'(busy_w[k]), 32'd0);
      end
    end
    if_enable = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("gate.start", 32'(inta_n_w[k]), 32'd0);
    drain();
    // back-pressure
    int_in = 1; data_in = 8'h5A;
    wait_valid("bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("bp.inta_n", 32'(inta_n_w[k]), 32'd1);
        chk("bp.vector", 32'(vec_w[k]), 32'h5A);
      end
    end
    vector_ready = 1;
    @(negedge clk);
    vector_ready = 0;
    for (int k = 0; k < 2; k++) chk("bp.idle", 32'(busy_w[k]), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("bp.restart", 32'(inta_n_w[k]), 32'd0);
    drain();
    // spurious: int_in drops during GAP of the default instance
    int_in = 1; data_in = 8'h4F;
    repeat (5) @(negedge clk);
    chk("spur.gap", 32'(inta_n_w[0] && busy_w[0]), 32'd1);
    int_in = 0;
    wait_valid("spur");
    for (int k = 0; k < 2; k++) chk("spur.vector", 32'(vec_w[k]), 32'h4F);
    drain();
    // asynchronous reset in ACK2
    int_in = 1;
    begin
      int t = 0;
      while (!(m_act[0] && m_e[0] >= pc[0] + gc[0]) && t < 40) begin @(negedge clk); t++; end
      chk("rstmid.timeout", 32'(t < 40), 32'd1);
    end
    @(posedge clk); #3;
    chk_on = 0; rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rstmid.inta_n", 32'(inta_n_w[k]), 32'd1);
      chk("rstmid.valid", 32'(valid_w[k]), 32'd0);
      chk("rstmid.count", 32'(cnt_w[k]), 32'd0);
      chk("rstmid.vector", 32'(vec_w[k]), 32'd0);
    end
    int_in = 0;
    @(negedge clk); rst_n = 1; chk_on = 1;
    repeat (10) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk("rstmid.idle", 32'(busy_w[k]), 32'd0);
    end
    // random traffic through irq_count wrap
    for (int c = 0; c < 20000 && m_acc[1] < 260; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        if (!seen[k] && m_acc[k] == 256) begin
          seen[k] = 1;
          chk("wrap.count", 32'(cnt_w[k]), 32'd0);
        end
      int_in = $urandom_range(0, 9) != 0;
      if_enable = $urandom_range(0, 7) != 0;
      vector_ready = $urandom_range(0, 2) != 0;
      data_in = 8'($urandom);
    end
    for (int k = 0; k < 2; k++) chk("wrap.reached", 32'(seen[k]), 32'd1);
    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
